// File: rtl/step_sequencer.sv
// rtl/step_sequencer.sv - instruction sequencer: PC, fetch handshake, T0..T3 step code
// Run/pause and single-step control, fetch watchdog, sticky error and retired-instruction counter.
module step_sequencer #(
    parameter int ADDR_W  = 8,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    input  logic              step_mode,
    input  logic              done,
    input  logic              mem_rdy,
    input  logic              pc_load,
    input  logic [ADDR_W-1:0] pc_din,
    input  logic              err_clr,
    output logic [1:0]        state,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [ADDR_W-1:0] pc,
    output logic              busy,
    output logic              err,
    output logic [15:0]       instr_count
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_EXEC  = 2'd2
    } fsm_t;

    localparam logic [1:0] T0 = 2'd0;
    localparam logic [1:0] T1 = 2'd1;
    localparam logic [1:0] T2 = 2'd2;
    localparam logic [1:0] T3 = 2'd3;
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    fsm_t              fsm_q, fsm_d;
    logic [1:0]        step_q, step_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              mem_req_q, mem_req_d;
    logic              busy_q, busy_d;
    logic              err_q, err_d;
    logic [15:0]       cnt_q, cnt_d;
    logic [7:0]        wait_q, wait_d;
    logic              run_q, run_d;
    logic              start;

    always_comb begin
        start = ~err_q & (step_mode ? (run & ~run_q) : run);
    end

    always_comb begin
        fsm_d     = fsm_q;
        step_d    = step_q;
        pc_d      = pc_q;
        mem_req_d = mem_req_q;
        busy_d    = busy_q;
        cnt_d     = cnt_q;
        wait_d    = wait_q;
        run_d     = run;
        // error events below override a same-cycle clear
        err_d     = err_q & ~err_clr;

        case (fsm_q)
            S_IDLE: begin
                step_d    = T0;
                mem_req_d = 1'b0;
                busy_d    = 1'b0;
                if (pc_load) begin
                    pc_d = pc_din;
                end
                if (start) begin
                    fsm_d     = S_FETCH;
                    mem_req_d = 1'b1;
                    busy_d    = 1'b1;
                    wait_d    = 8'd0;
                end
            end

            S_FETCH: begin
                step_d = T0;
                if (mem_rdy) begin
                    pc_d      = pc_q + ADDR_W'(1);
                    step_d    = T1;
                    fsm_d     = S_EXEC;
                    mem_req_d = 1'b0;
                    wait_d    = 8'd0;
                end else if (wait_q == WAIT_LAST) begin
                    err_d     = 1'b1;
                    fsm_d     = S_IDLE;
                    mem_req_d = 1'b0;
                    busy_d    = 1'b0;
                    wait_d    = 8'd0;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end

            S_EXEC: begin
                if ((step_q == T1 || step_q == T3) && done) begin
                    cnt_d  = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
                    step_d = T0;
                    if (run && !step_mode) begin
                        fsm_d     = S_FETCH;
                        mem_req_d = 1'b1;
                    end else begin
                        fsm_d  = S_IDLE;
                        busy_d = 1'b0;
                    end
                end else if (step_q == T3) begin
                    err_d  = 1'b1;
                    step_d = T0;
                    fsm_d  = S_IDLE;
                    busy_d = 1'b0;
                end else begin
                    step_d = step_q + 2'd1;
                end
            end

            default: begin
                fsm_d     = S_IDLE;
                step_d    = T0;
                mem_req_d = 1'b0;
                busy_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fsm_q     <= S_IDLE;
            step_q    <= T0;
            pc_q      <= '0;
            mem_req_q <= 1'b0;
            busy_q    <= 1'b0;
            err_q     <= 1'b0;
            cnt_q     <= 16'd0;
            wait_q    <= 8'd0;
            run_q     <= 1'b0;
        end else begin
            fsm_q     <= fsm_d;
            step_q    <= step_d;
            pc_q      <= pc_d;
            mem_req_q <= mem_req_d;
            busy_q    <= busy_d;
            err_q     <= err_d;
            cnt_q     <= cnt_d;
            wait_q    <= wait_d;
            run_q     <= run_d;
        end
    end

    assign state       = step_q;
    assign mem_req     = mem_req_q;
    assign mem_addr    = pc_q;
    assign pc          = pc_q;
    assign busy        = busy_q;
    assign err         = err_q;
    assign instr_count = cnt_q;

endmodule
